// File: rtl/load_store_arbiter_pkg.sv
// Shared types and constants for the load/store arbiter.
package load_store_pkg;

  typedef enum logic {
    DRAIN = 1'b0,
    FILL  = 1'b1
  } mode_t;

  localparam logic DIR_LOAD  = 1'b1;
  localparam logic DIR_STORE = 1'b0;

endpackage

// File: rtl/load_store_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   first;
  logic [2*NREQ-1:0] hit;
  logic              found;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the hit back.
  always_comb begin
    dbl   = {elig, elig};
    rot   = NREQ'(dbl >> ptr);
    first = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!found && rot[k]) begin
        first[k] = 1'b1;
        found    = 1'b1;
      end
    end
    hit   = {{NREQ{1'b0}}, first} << ptr;
    pick  = hit[NREQ-1:0] | hit[2*NREQ-1:NREQ];
    valid = |elig;
  end

endmodule

// File: rtl/load_store_arbiter.sv
// Round-robin load/store arbiter over a bounded volume counter with FILL/DRAIN hysteresis.
module load_store_arbiter
  import load_store_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned N     = 2500,
  parameter int unsigned CBITS = 12,
  parameter int unsigned TMO   = 16,
  parameter int unsigned TBITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  dir,
  output logic [NREQ-1:0]  gnt,
  output logic [CBITS-1:0] vol,
  output logic             mode,
  output logic             full,
  output logic             empty,
  output logic             sig
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  mode_t            mode_q, mode_d;
  logic [CBITS-1:0] vol_q, vol_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [TBITS-1:0] starve_q, starve_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;

  logic [NREQ-1:0]  cap_ok;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  elig_opp;
  logic [NREQ-1:0]  pick;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic             starve_cond;
  logic             starve_hit;

  // Eligibility under the current mode and under the opposite mode.
  always_comb begin
    cap_ok   = '0;
    elig     = '0;
    elig_opp = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cap_ok[i]   = ((dir[i] == DIR_LOAD)  && (vol_q < CBITS'(N))) ||
                    ((dir[i] == DIR_STORE) && (vol_q != '0));
      elig[i]     = req[i] && !gnt_q[i] && cap_ok[i] && (mode_t'(dir[i]) == mode_q);
      elig_opp[i] = req[i] && !gnt_q[i] && cap_ok[i] && (mode_t'(dir[i]) != mode_q);
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // One-hot pick to index, for advancing the round-robin pointer.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // Next-state: grant, volume, pointer, mode FSM and starvation counter.
  always_comb begin
    gnt_d    = '0;
    vol_d    = vol_q;
    ptr_d    = ptr_q;
    mode_d   = mode_q;
    starve_d = '0;

    starve_cond = !(|elig) && (|elig_opp);
    starve_hit  = starve_cond && (starve_q == TBITS'(TMO - 1));

    if (pick_valid) begin
      gnt_d = pick;
      vol_d = (mode_q == FILL) ? vol_q + CBITS'(1) : vol_q - CBITS'(1);
      ptr_d = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
    end

    case (mode_q)
      FILL: begin
        if (vol_q == CBITS'(N)) mode_d = DRAIN;
        else if (starve_hit)    mode_d = DRAIN;
      end
      DRAIN: begin
        if (vol_q == '0)     mode_d = FILL;
        else if (starve_hit) mode_d = FILL;
      end
      default: mode_d = FILL;
    endcase

    // Saturating count of consecutive starved cycles in an unchanged mode.
    if (!pick_valid && (mode_d == mode_q) && starve_cond) begin
      starve_d = (starve_q == TBITS'(TMO - 1)) ? starve_q : starve_q + TBITS'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= FILL;
      vol_q    <= '0;
      ptr_q    <= '0;
      starve_q <= '0;
      gnt_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      vol_q    <= vol_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
      gnt_q    <= gnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign vol   = vol_q;
  assign mode  = mode_q;
  assign full  = (vol_q == CBITS'(N));
  assign empty = (vol_q == '0);
  assign sig   = full;

endmodule

// File: tb/tb_load_store_arbiter.sv
// Self-checking bench for load_store_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_load_store_arbiter;

  localparam int NREQ  = 4;
  localparam int N     = 8;
  localparam int CBITS = 4;
  localparam int TMO   = 4;
  localparam int TBITS = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  dir = '0;
  logic [NREQ-1:0]  gnt;
  logic [CBITS-1:0] vol;
  logic             mode, full, empty, sig;

  int total = 0;
  int bad   = 0;

  // Reference model state (spec-level quantities).
  int       m_vol;
  int       m_ptr;
  int       m_starve;
  bit       m_fill;
  bit [3:0] m_gnt;

  load_store_arbiter #(
    .NREQ(NREQ), .N(N), .CBITS(CBITS), .TMO(TMO), .TBITS(TBITS)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .gnt(gnt),
    .vol(vol), .mode(mode), .full(full), .empty(empty), .sig(sig)
  );

  always #5 clk = ~clk;

  function automatic bit can_go(int i, bit fill_mode);
    bit cap;
    cap = dir[i] ? (m_vol < N) : (m_vol > 0);
    return req[i] && !m_gnt[i] && (dir[i] == fill_mode) && cap;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int  pick;
    bit  any_cur, any_opp, changed;
    bit  new_fill;
    if (rst) begin
      m_vol = 0; m_ptr = 0; m_starve = 0; m_fill = 1'b1; m_gnt = '0;
      return;
    end
    pick = -1;
    any_cur = 0; any_opp = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (can_go(i, m_fill))  any_cur = 1;
      if (can_go(i, !m_fill)) any_opp = 1;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (pick < 0 && can_go((m_ptr + k) % NREQ, m_fill)) pick = (m_ptr + k) % NREQ;
    end
    new_fill = m_fill;
    if (m_fill && m_vol == N) new_fill = 0;
    else if (!m_fill && m_vol == 0) new_fill = 1;
    else if (m_starve == TMO - 1 && !any_cur && any_opp) new_fill = !m_fill;
    changed = (new_fill != m_fill);
    if (pick >= 0 || changed || any_cur || !any_opp) m_starve = 0;
    else if (m_starve < TMO - 1) m_starve = m_starve + 1;
    m_gnt = '0;
    if (pick >= 0) begin
      m_gnt[pick] = 1'b1;
      m_vol = m_vol + (m_fill ? 1 : -1);
      m_ptr = (pick + 1) % NREQ;
    end
    m_fill = new_fill;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; dir = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (vol !== 4'd0) begin bad++; $display("FAIL reset_vol got=%0d exp=0", vol); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (mode !== 1'b1) begin bad++; $display("FAIL reset_mode got=%b exp=1", mode); end
    total++; if ({full, empty, sig} !== 3'b010) begin bad++; $display("FAIL reset_flags got=%b exp=010", {full, empty, sig}); end
  endtask

  task automatic test_single_loader();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0001; dir = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++; if (gnt !== 4'b0001 || vol !== 4'(k)) begin bad++; $display("FAIL single_grant k=%0d got gnt=%b vol=%0d exp gnt=0001 vol=%0d", k, gnt, vol, k); end
      if (k < 8) begin
        tick();
        total++; if (gnt !== 4'b0000 || vol !== 4'(k)) begin bad++; $display("FAIL single_gap k=%0d got gnt=%b vol=%0d exp gnt=0000 vol=%0d", k, gnt, vol, k); end
      end
    end
    total++; if ({full, sig, mode} !== 3'b111) begin bad++; $display("FAIL single_full got=%b exp=111", {full, sig, mode}); end
    tick();
    total++; if (mode !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL single_to_drain got mode=%b gnt=%b exp mode=0 gnt=0000", mode, gnt); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (gnt !== 4'b0000 || vol !== 4'd8) begin bad++; $display("FAIL single_hold got gnt=%b vol=%0d exp gnt=0000 vol=8", gnt, vol); end
    end
  endtask

  task automatic test_round_robin();
    bit [3:0] exp_g;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; dir = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = 4'b0001 << ((k - 1) % 4);
      total++; if (gnt !== exp_g || vol !== 4'(k)) begin bad++; $display("FAIL rr k=%0d got gnt=%b vol=%0d exp gnt=%b vol=%0d", k, gnt, vol, exp_g, k); end
    end
    tick();
    total++; if (mode !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL rr_to_drain got mode=%b gnt=%b exp mode=0 gnt=0000", mode, gnt); end
  endtask

  task automatic test_drain();
    bit [3:0] exp_g;
    req = 4'b0110; dir = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = (k % 2 == 1) ? 4'b0010 : 4'b0100;
      total++; if (gnt !== exp_g || vol !== 4'(8 - k)) begin bad++; $display("FAIL drain k=%0d got gnt=%b vol=%0d exp gnt=%b vol=%0d", k, gnt, vol, exp_g, 8 - k); end
    end
    total++; if (empty !== 1'b1 || mode !== 1'b0) begin bad++; $display("FAIL drain_empty got empty=%b mode=%b exp empty=1 mode=0", empty, mode); end
    tick();
    total++; if (mode !== 1'b1 || gnt !== 4'b0000) begin bad++; $display("FAIL drain_to_fill got mode=%b gnt=%b exp mode=1 gnt=0000", mode, gnt); end
    tick();
    total++; if (gnt !== 4'b0000 || vol !== 4'd0) begin bad++; $display("FAIL drain_no_store got gnt=%b vol=%0d exp gnt=0000 vol=0", gnt, vol); end
  endtask

  task automatic fill_to_three();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0011; dir = 4'b0011;
    tick(); tick(); tick();
  endtask

  task automatic test_starvation();
    fill_to_three();
    total++; if (vol !== 4'd3 || mode !== 1'b1) begin bad++; $display("FAIL starve_setup got vol=%0d mode=%b exp vol=3 mode=1", vol, mode); end
    req = 4'b0100; dir = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (mode !== 1'b1 || gnt !== 4'b0000 || vol !== 4'd3) begin bad++; $display("FAIL starve_wait k=%0d got mode=%b gnt=%b vol=%0d exp mode=1 gnt=0000 vol=3", k, mode, gnt, vol); end
    end
    tick();
    total++; if (mode !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL starve_toggle got mode=%b gnt=%b exp mode=0 gnt=0000", mode, gnt); end
    tick();
    total++; if (gnt !== 4'b0100 || vol !== 4'd2) begin bad++; $display("FAIL starve_grant got gnt=%b vol=%0d exp gnt=0100 vol=2", gnt, vol); end
  endtask

  task automatic test_mixed();
    fill_to_three();
    req = 4'b0110; dir = 4'b0010;
    for (int j = 0; j < 5; j++) begin
      tick();
      total++; if (gnt !== 4'b0010 || vol !== 4'(4 + j) || mode !== 1'b1) begin bad++; $display("FAIL mixed_load j=%0d got gnt=%b vol=%0d mode=%b exp gnt=0010 vol=%0d mode=1", j, gnt, vol, mode, 4 + j); end
      if (j < 4) begin
        tick();
        total++; if (gnt !== 4'b0000 || mode !== 1'b1) begin bad++; $display("FAIL mixed_gap j=%0d got gnt=%b mode=%b exp gnt=0000 mode=1", j, gnt, mode); end
      end
    end
    tick();
    total++; if (mode !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL mixed_to_drain got mode=%b gnt=%b exp mode=0 gnt=0000", mode, gnt); end
    tick();
    total++; if (gnt !== 4'b0100 || vol !== 4'd7) begin bad++; $display("FAIL mixed_store got gnt=%b vol=%0d exp gnt=0100 vol=7", gnt, vol); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1000; dir = 4'b1000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) tick();
    end
    total++; if (vol !== 4'd5 || gnt !== 4'b1000) begin bad++; $display("FAIL midrst_setup got vol=%0d gnt=%b exp vol=5 gnt=1000", vol, gnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (vol !== 4'd0 || gnt !== 4'b0000 || mode !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL midrst_state got vol=%0d gnt=%b mode=%b empty=%b exp vol=0 gnt=0000 mode=1 empty=1", vol, gnt, mode, empty); end
    req = 4'b1001; dir = 4'b1001;
    tick();
    total++; if (gnt !== 4'b0001 || vol !== 4'd1) begin bad++; $display("FAIL midrst_first got gnt=%b vol=%0d exp gnt=0001 vol=1", gnt, vol); end
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req = 4'($urandom_range(0, 15));
      dir = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = req & 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      tick();
      total++;
      if (gnt !== m_gnt || vol !== 4'(m_vol) || mode !== m_fill ||
          full !== (m_vol == N) || empty !== (m_vol == 0) || sig !== (m_vol == N)) begin
        bad++;
        $display("FAIL random cyc=%0d got gnt=%b vol=%0d mode=%b f/e/s=%b%b%b exp gnt=%b vol=%0d mode=%b f/e/s=%b%b%b",
                 c, gnt, vol, mode, full, empty, sig, m_gnt, m_vol, m_fill,
                 (m_vol == N), (m_vol == 0), (m_vol == N));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_vol = 0; m_ptr = 0; m_starve = 0; m_fill = 1'b1; m_gnt = '0;
    #1;
    test_reset();
    test_single_loader();
    test_round_robin();
    test_drain();
    test_starvation();
    test_mixed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
